// File: rtl/terminal_pkg.sv
// Shared constants and types for the terminal grid stream blocks.
package terminal_pkg;

  localparam int DEF_SCREEN_WIDTH  = 76;
  localparam int DEF_SCREEN_HEIGHT = 44;
  localparam int TLR_ADDR_W        = $clog2(DEF_SCREEN_WIDTH * DEF_SCREEN_HEIGHT);
  localparam int TLR_ROW_W         = $clog2(DEF_SCREEN_HEIGHT);

  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } tlr_state_t;

endpackage

// File: rtl/tlr_return_fifo.sv
// Small synchronous FIFO with flush and a two-entry peek (head and the entry behind it).
module tlr_return_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] next_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign next_data = mem[wrap_inc(rd_ptr)];

endmodule

// File: rtl/terminal_line_reader.sv
// Scans one row of the terminal grid and streams it as a valid/ready byte stream with a last flag.
// Build option TLR_EOL_BYTE_EN appends a CR byte (carrying last) after every line.
module terminal_line_reader #(
  parameter int SCREEN_WIDTH  = terminal_pkg::DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = terminal_pkg::DEF_SCREEN_HEIGHT,
  parameter int RD_LATENCY    = 2,
  parameter int FIFO_DEPTH    = RD_LATENCY + 2
) (
  input  logic                                          pixel_clk_in,
  input  logic                                          rst_in,
  input  logic                                          start_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]              row_in,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_rd_addr_out,
  output logic                                          tg_rd_en_out,
  input  logic [7:0]                                    tg_rd_data_in,
  output logic [7:0]                                    char_out,
  output logic                                          char_valid_out,
  input  logic                                          char_ready_in,
  output logic                                          char_last_out,
  output logic                                          busy_out,
  output logic                                          done_out,
  output logic                                          err_out,
  output logic [1:0]                                    dbg_state_out
);
  import terminal_pkg::*;

  localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int ROW_W  = $clog2(SCREEN_HEIGHT);
  localparam int COL_W  = $clog2(SCREEN_WIDTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W + 1)'(SCREEN_HEIGHT);
`ifdef TLR_EOL_BYTE_EN
  localparam logic EOL_EN = 1'b1;
`else
  localparam logic EOL_EN = 1'b0;
`endif

  // Handshake: a byte moves when char_valid_out and char_ready_in are both high at a
  // rising edge; while valid is high and ready is low, char_out/char_last_out hold.

  tlr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  head_col_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [RD_LATENCY-1:0] tag_q;
  logic              pending_cr_q;
  logic [7:0]        char_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic              err_q;

  logic              ret_valid;
  logic              push;
  logic              pop;
  logic              fifo_flush;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        head_data;
  logic [7:0]        next_data;
  logic              multi_entries;
  logic              succ_valid;
  logic [7:0]        succ_data;
  logic              credit_ok;
  logic              rd_en;
  logic              can_load;
  logic              xfer;
  logic              row_ok;
  logic              start_ok;
  logic              load;
  logic [7:0]        load_data;
  logic              load_last;
  logic              set_cr;
  logic              clr_cr;
  logic              done_d;
  logic              err_d;

  tlr_return_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (pixel_clk_in),
    .rst_n     (rst_in),
    .push      (push),
    .push_data (tg_rd_data_in),
    .pop       (pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head_data (head_data),
    .next_data (next_data)
  );

  assign ret_valid     = tag_q[RD_LATENCY-1];
  assign push          = ret_valid && ((state_q == FETCH) || (state_q == DRAIN));
  assign inflight_nxt  = inflight_q + CNT_W'(rd_en) - CNT_W'(ret_valid);
  assign credit_ok     = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign xfer          = valid_q && char_ready_in;
  assign can_load      = !valid_q || char_ready_in;
  assign row_ok        = {1'b0, row_in} < ROW_LIMIT;
  // The successor of the head may be the byte returning from the grid this very cycle.
  assign multi_entries = fifo_count > CNT_W'(1);
  assign succ_valid    = multi_entries || push;
  assign succ_data     = multi_entries ? next_data : tg_rd_data_in;

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    pop        = 1'b0;
    fifo_flush = (state_q == FLUSH);
    load       = 1'b0;
    load_data  = head_data;
    load_last  = 1'b0;
    set_cr     = 1'b0;
    clr_cr     = 1'b0;
    start_ok   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          if (row_ok) begin
            start_ok = 1'b1;
            state_d  = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH, DRAIN: begin
        if ((state_q == FETCH) && credit_ok) begin
          rd_en = 1'b1;
          if (col_q == LAST_COL) state_d = DRAIN;
        end
        if (fifo_count != '0) begin
          // A NUL can only reach the head at column 0: later NULs are caught as successors.
          if (head_data == CHAR_NUL) begin
            set_cr  = EOL_EN;
            state_d = FLUSH;
          end else if (head_col_q == LAST_COL) begin
            if (can_load) begin
              load      = 1'b1;
              pop       = 1'b1;
              load_last = !EOL_EN;
              set_cr    = EOL_EN;
              state_d   = FLUSH;
            end
          end else if (succ_valid && can_load) begin
            load = 1'b1;
            pop  = 1'b1;
            if (succ_data == CHAR_NUL) begin
              load_last = !EOL_EN;
              set_cr    = EOL_EN;
              state_d   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (pending_cr_q) begin
          if (can_load) begin
            load      = 1'b1;
            load_data = CHAR_CR;
            load_last = 1'b1;
            clr_cr    = 1'b1;
          end
        end else if ((inflight_nxt == '0) && can_load) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      col_q        <= '0;
      head_col_q   <= '0;
      inflight_q   <= '0;
      tag_q        <= '0;
      pending_cr_q <= 1'b0;
      char_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_nxt;
      for (int i = RD_LATENCY - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
      tag_q[0] <= rd_en;
      if (start_ok) begin
        addr_q     <= ADDR_W'(row_in) * ADDR_W'(SCREEN_WIDTH);
        col_q      <= '0;
        head_col_q <= '0;
      end else begin
        if (rd_en) begin
          addr_q <= addr_q + ADDR_W'(1);
          col_q  <= col_q + COL_W'(1);
        end
        if (pop) head_col_q <= head_col_q + COL_W'(1);
      end
      if (set_cr)      pending_cr_q <= 1'b1;
      else if (clr_cr) pending_cr_q <= 1'b0;
      if (load) begin
        char_q  <= load_data;
        last_q  <= load_last;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign tg_rd_addr_out = addr_q;
  assign tg_rd_en_out   = rd_en;
  assign char_out       = char_q;
  assign char_valid_out = valid_q;
  assign char_last_out  = last_q;
  assign busy_out       = (state_q != IDLE);
  assign done_out       = done_q;
  assign err_out        = err_q;
  assign dbg_state_out  = state_q;

endmodule

// File: tb/tb_terminal_line_reader.sv
// Scoreboard bench for terminal_line_reader: directed rows, backpressure, reset and latency sweep.
`timescale 1ns/1ps
module tb_terminal_line_reader;

  localparam int W  = 76;
  localparam int H  = 44;
  localparam int AW = 12;
  localparam int RW = 6;
  localparam int L  = 2;
  localparam int D  = L + 2;
`ifdef TLR_EOL_BYTE_EN
  localparam bit EOL = 1'b1;
`else
  localparam bit EOL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (latency 2) ----------------
  logic          start;
  logic [RW-1:0] row;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic [7:0]    ch;
  logic          valid, ready, last, busy, done, err;
  logic [1:0]    dbg_state;

  terminal_line_reader #(.RD_LATENCY(L)) dut (
    .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start), .row_in(row),
    .tg_rd_addr_out(rd_addr), .tg_rd_en_out(rd_en), .tg_rd_data_in(rd_data),
    .char_out(ch), .char_valid_out(valid), .char_ready_in(ready),
    .char_last_out(last), .busy_out(busy), .done_out(done), .err_out(err),
    .dbg_state_out(dbg_state)
  );

  // ---------------- DUT (latency 4) ----------------
  logic          start4;
  logic [RW-1:0] row4;
  logic [AW-1:0] rd_addr4;
  logic          rd_en4;
  logic [7:0]    rd_data4;
  logic [7:0]    ch4;
  logic          valid4, last4, busy4, done4, err4;
  logic          ready4;
  logic [1:0]    dbg_state4;

  terminal_line_reader #(.RD_LATENCY(4)) dut4 (
    .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start4), .row_in(row4),
    .tg_rd_addr_out(rd_addr4), .tg_rd_en_out(rd_en4), .tg_rd_data_in(rd_data4),
    .char_out(ch4), .char_valid_out(valid4), .char_ready_in(ready4),
    .char_last_out(last4), .busy_out(busy4), .done_out(done4), .err_out(err4),
    .dbg_state_out(dbg_state4)
  );

  // ---------------- grid RAM models ----------------
  logic [7:0] mem [W*H];
  logic [7:0] rp2 [2];
  logic [7:0] rp4 [4];
  always @(posedge clk) begin
    rp2[0] <= mem[rd_addr];
    rp2[1] <= rp2[0];
    rp4[0] <= mem[rd_addr4];
    for (int i = 1; i < 4; i++) rp4[i] <= rp4[i-1];
  end
  assign rd_data  = rp2[1];
  assign rd_data4 = rp4[3];

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp4_q[$];
  int checks = 0;
  int errors = 0;
  int exp_addr, row_end, issued, xfers, done_cnt, err_cnt;
  int start_cyc, first_cyc, last_cyc, done_cyc;
  int first4, last4_cyc;
  bit first_seen, first4_seen, ready_rand;
  bit stall_prev;
  logic [8:0] stall_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ready: always 1, or high ~30% of cycles
  always @(posedge clk) begin
    #1;
    ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // ---------------- monitor (main DUT) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("rd_in_row", 32'(int'(rd_addr) < row_end), 32'd1);
        check("rd_credit", 32'((issued - xfers - int'(valid)) < D), 32'd1);
        exp_addr++;
        issued++;
      end
      if (stall_prev) check("stall_hold", {23'd0, valid, last, ch}, {23'd0, 1'b1, stall_val});
      stall_prev = valid && !ready;
      stall_val  = {last, ch};
      if (valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, last, ch}, 32'h1ff);
        end else begin
          check("byte", {23'd0, last, ch}, {23'd0, exp_q.pop_front()});
        end
        xfers++;
        last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (err) err_cnt++;
    end
  end

  // ---------------- monitor (latency-4 DUT) ----------------
  always @(negedge clk) begin
    if (rst_n && valid4) begin
      if (!first4_seen) begin
        first4_seen = 1'b1;
        first4      = cyc;
      end
      if (exp4_q.size() == 0) check("l4_unexpected_byte", {23'd0, last4, ch4}, 32'h1ff);
      else check("l4_byte", {23'd0, last4, ch4}, {23'd0, exp4_q.pop_front()});
      last4_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_row(input int r);
    exp_addr   = r * W;
    row_end    = r * W + W;
    issued     = 0;
    xfers      = 0;
    first_seen = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    row       = RW'(r);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done_cnt - d0), 32'd1);
    repeat (3) @(negedge clk);
    check({name, "_once"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Bytes up to the first NUL, last on the final one (or on an appended CR).
  task automatic expect_row(input int r);
    int n;
    n = 0;
    while (n < W && mem[r*W+n] != 8'h00) n++;
    for (int c = 0; c < n; c++) exp_q.push_back({(c == n - 1) && !EOL, mem[r*W+c]});
    if (EOL) exp_q.push_back({1'b1, 8'h0D});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit stray;
    logic [7:0] a_char;
    for (int a = 0; a < W*H; a++) mem[a] = 8'h21 + 8'(a % 90);
    for (int c = 0; c < W; c++) mem[3*W+c] = 8'h41 + 8'(c);
    mem[0] = 8'h6c; mem[1] = 8'h73; mem[2] = 8'h00;
    mem[7*W] = 8'h00;
    rst_n = 1'b0; start = 1'b0; row = '0; start4 = 1'b0; row4 = '0;
    ready4 = 1'b1; ready_rand = 1'b0; ready = 1'b1;
    done_cnt = 0; err_cnt = 0; stall_prev = 1'b0;
    first4_seen = 1'b0; done_cyc = 0; last_cyc = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {valid, last, busy, done, err, rd_en, dbg_state, ch, 4'd0, rd_addr},
          32'd0);
    rst_n = 1'b1;

    // Full row 3: 'A'..'A'+75 at addresses 228..303, ready held high.
    for (int c = 0; c < W; c++) begin
      a_char = 8'h41 + 8'(c);
      exp_q.push_back({(c == W - 1) && !EOL, a_char});
    end
    if (EOL) exp_q.push_back({1'b1, 8'h0D});
    start_row(3);
    check("full_first_addr", 32'(exp_addr - issued), 32'd228);
    wait_done("full_done");
    check("full_reads", 32'(issued), 32'd76);
    check("full_latency", 32'((first_cyc - start_cyc) >= 3 + L), 32'd1);
    check("full_throughput", 32'(last_cyc - first_cyc), EOL ? 32'd76 : 32'd75);
    check("full_done_timing", 32'(done_cyc - last_cyc), 32'd1);
    check("full_busy_after", 32'(busy), 32'd0);

    // NUL stop: row 0 = "ls\0...".
    exp_q.push_back({1'b0, 8'h6c});
    exp_q.push_back({!EOL, 8'h73});
    if (EOL) exp_q.push_back({1'b1, 8'h0D});
    start_row(0);
    wait_done("nul_done");
    check("nul_xfers", 32'(xfers), EOL ? 32'd3 : 32'd2);
    expect_row(1);
    start_row(1);
    wait_done("after_nul_done");

    // Backpressure on row 4.
    ready_rand = 1'b1;
    expect_row(4);
    start_row(4);
    wait_done("bp_done");
    check("bp_xfers", 32'(xfers), EOL ? 32'd77 : 32'd76);
    ready_rand = 1'b0;

    // Empty line (row 7 col 0 = NUL).
    expect_row(7);
    start_row(7);
    wait_done("empty_done");
    check("empty_xfers", 32'(xfers), EOL ? 32'd1 : 32'd0);

    // Invalid row 44.
    k = err_cnt;
    start_row(44);
    @(negedge clk);
    check("err_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("err_pulse", 32'(err_cnt - k), 32'd1);
    check("err_no_read", 32'(issued), 32'd0);

    // Reset mid-scan on row 2 around column 20.
    expect_row(2);
    start_row(2);
    k = 0;
    while (issued < 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached_col20", 32'(issued >= 20), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {valid, last, busy, done, err, rd_en, dbg_state, 12'd0, rd_addr},
          32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      stray = stray | valid;
    end
    check("no_stray_valid", 32'(stray), 32'd0);
    expect_row(5);
    start_row(5);
    check("row5_first_addr", 32'(exp_addr - issued), 32'd380);
    wait_done("row5_done");

    // Latency-4 instance on row 3.
    for (int c = 0; c < W; c++) begin
      a_char = 8'h41 + 8'(c);
      exp4_q.push_back({(c == W - 1) && !EOL, a_char});
    end
    if (EOL) exp4_q.push_back({1'b1, 8'h0D});
    @(posedge clk); #1;
    start4 = 1'b1; row4 = RW'(3);
    k = cyc;
    @(posedge clk); #1;
    start4 = 1'b0;
    begin
      int j;
      j = 0;
      while (!done4 && j < 2000) begin
        @(negedge clk);
        j++;
      end
    end
    check("l4_done", 32'(done4), 32'd1);
    check("l4_drained", 32'(exp4_q.size()), 32'd0);
    check("l4_latency", 32'((first4 - k) >= 3 + 4), 32'd1);
    check("l4_throughput", 32'(last4_cyc - first4), EOL ? 32'd76 : 32'd75);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
